// File: rtl/scr1_imem_ahb_q.sv
//------------------------------------------------------------------------------
// scr1_imem_ahb_q -- instruction fetch bridge: queued core fetch requests are
// issued as pipelined single AHB-Lite reads. Responses return in order.
//
// Build option: define SCR1_IMEM_AHB_Q_RESP_REG_EN to register imem_rdata and
// imem_resp (response one cycle after the data beat). Without it, hrdata/hresp
// pass straight through in the data-beat cycle.
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   imem_req          fetch request; accepted when imem_req_ack is high
//   imem_req_ack      queue can take a request this cycle
//   imem_addr         word-aligned fetch address
//   imem_flush        redirect: drop queued and in-flight fetches
//   imem_rdata        fetched word
//   imem_resp         NOTRDY / RDY_OK / RDY_ER
//   req_cnt           request queue occupancy
//   h*                AHB-Lite master signals
//------------------------------------------------------------------------------
package scr1_imem_ahb_q_pkg;

   localparam int unsigned SCR1_AHB_WIDTH = 32;

   typedef enum logic [1:0] {
      SCR1_MEM_RESP_NOTRDY = 2'b00,
      SCR1_MEM_RESP_RDY_OK = 2'b01,
      SCR1_MEM_RESP_RDY_ER = 2'b10
   } type_scr1_mem_resp_e;

   localparam logic [1:0] SCR1_HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] SCR1_HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] SCR1_HBURST_SINGLE = 3'b000;
   localparam logic [2:0] SCR1_HSIZE_32B     = 3'b010;
   localparam logic       SCR1_HRESP_ERROR   = 1'b1;

endpackage

module scr1_imem_ahb_q
   import scr1_imem_ahb_q_pkg::*;
#(
   parameter int unsigned REQ_FIFO_DEPTH = 2
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 imem_req,
   output logic                                 imem_req_ack,
   input  logic [SCR1_AHB_WIDTH-1:0]            imem_addr,
   input  logic                                 imem_flush,
   output logic [SCR1_AHB_WIDTH-1:0]            imem_rdata,
   output type_scr1_mem_resp_e                  imem_resp,
   output logic [$clog2(REQ_FIFO_DEPTH+1)-1:0]  req_cnt,
   output logic [3:0]                           hprot,
   output logic [2:0]                           hburst,
   output logic [2:0]                           hsize,
   output logic [1:0]                           htrans,
   output logic                                 hmastlock,
   output logic [SCR1_AHB_WIDTH-1:0]            haddr,
   input  logic                                 hready,
   input  logic [SCR1_AHB_WIDTH-1:0]            hrdata,
   input  logic                                 hresp
);

   localparam int unsigned CNT_W = $clog2(REQ_FIFO_DEPTH + 1);
   localparam int unsigned PTR_W = (REQ_FIFO_DEPTH > 1) ? $clog2(REQ_FIFO_DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(REQ_FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(REQ_FIFO_DEPTH);

   typedef enum logic {
      ST_ADDR = 1'b0,
      ST_DATA = 1'b1
   } state_e;

   state_e                    state;
   logic [SCR1_AHB_WIDTH-1:0] q_addr [REQ_FIFO_DEPTH];
   logic [PTR_W-1:0]          rd_ptr;
   logic [PTR_W-1:0]          wr_ptr;
   logic [CNT_W-1:0]          cnt;
   logic                      drop;

   logic full;
   logic empty;
   logic push;
   logic pop;
   logic issue;
   logic beat;
   logic beat_err;
   logic clear;
   logic resp_vld;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Constant AHB attributes: single 32-bit unlocked reads
   assign hprot     = 4'b0000;
   assign hburst    = SCR1_HBURST_SINGLE;
   assign hsize     = SCR1_HSIZE_32B;
   assign hmastlock = 1'b0;
   assign req_cnt   = cnt;

   // Queue status, request handshake and AHB address-phase decode
   always_comb begin
      full         = (cnt == CNT_FULL);
      empty        = (cnt == '0);
      imem_req_ack = ~full & ~imem_flush;
      push         = imem_req & imem_req_ack;
      beat         = (state == ST_DATA) & hready;
      beat_err     = beat & (hresp == SCR1_HRESP_ERROR);
      issue        = 1'b0;
      // A write into an empty queue is presented on the bus the same cycle
      if (state == ST_ADDR) begin
         issue = (~empty | push) & ~imem_flush;
      end else begin
         issue = hready & (hresp != SCR1_HRESP_ERROR) & (~empty | push) & ~imem_flush;
      end
      pop      = issue & hready;
      clear    = imem_flush | beat_err;
      // Flush in the beat cycle itself also suppresses that beat
      resp_vld = beat & ~drop & ~imem_flush;
      htrans   = issue ? SCR1_HTRANS_NONSEQ : SCR1_HTRANS_IDLE;
      haddr    = empty ? imem_addr : q_addr[rd_ptr];
   end

   // Bus FSM: ADDR waits for an address phase to be accepted, DATA tracks
   // the outstanding data phase and may pipeline the next address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_ADDR;
      end else begin
         case (state)
            ST_ADDR: if (pop) state <= ST_DATA;
            ST_DATA: if (hready) state <= issue ? ST_DATA : ST_ADDR;
            default: state <= ST_ADDR;
         endcase
      end
   end

   // Queue pointers and occupancy; flush and error beats empty the queue
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Queue storage carries no reset
   always_ff @(posedge clk) begin
      if (push) q_addr[wr_ptr] <= imem_addr;
   end

   // Drop flag marks a data phase that outlives the flush cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop <= 1'b0;
      end else if (imem_flush && (state == ST_DATA) && !hready) begin
         drop <= 1'b1;
      end else if (beat) begin
         drop <= 1'b0;
      end
   end

`ifdef SCR1_IMEM_AHB_Q_RESP_REG_EN
   logic                      resp_vld_q;
   logic                      resp_err_q;
   logic [SCR1_AHB_WIDTH-1:0] rdata_q;

   // Registered response: valid one cycle after the data beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_vld_q <= 1'b0;
         resp_err_q <= 1'b0;
      end else begin
         resp_vld_q <= resp_vld;
         resp_err_q <= beat_err;
      end
   end

   always_ff @(posedge clk) begin
      if (beat) rdata_q <= hrdata;
   end

   assign imem_rdata = rdata_q;

   always_comb begin
      imem_resp = SCR1_MEM_RESP_NOTRDY;
      if (resp_vld_q) begin
         imem_resp = resp_err_q ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
      end
   end
`else
   // Pass-through response: valid in the data-beat cycle
   assign imem_rdata = hrdata;

   always_comb begin
      imem_resp = SCR1_MEM_RESP_NOTRDY;
      if (resp_vld) begin
         imem_resp = beat_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
      end
   end
`endif

endmodule

// File: tb/tb_scr1_imem_ahb_q.sv
//------------------------------------------------------------------------------
// tb_scr1_imem_ahb_q -- directed self-checking bench for scr1_imem_ahb_q
// (queue depth 2). Responses are logged at the falling edge and compared
// in order against hand-derived expectations, including their cycle.
//------------------------------------------------------------------------------
module tb_scr1_imem_ahb_q;
   import scr1_imem_ahb_q_pkg::*;

   localparam int unsigned DEPTH = 2;
`ifdef SCR1_IMEM_AHB_Q_RESP_REG_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif
   localparam logic [1:0] OK = 2'b01;
   localparam logic [1:0] ER = 2'b10;

   logic                      clk;
   logic                      rst_n;
   logic                      imem_req;
   logic                      imem_req_ack;
   logic [31:0]               imem_addr;
   logic                      imem_flush;
   logic [31:0]               imem_rdata;
   type_scr1_mem_resp_e       imem_resp;
   logic [$clog2(DEPTH+1)-1:0] req_cnt;
   logic [3:0]                hprot;
   logic [2:0]                hburst;
   logic [2:0]                hsize;
   logic [1:0]                htrans;
   logic                      hmastlock;
   logic [31:0]               haddr;
   logic                      hready;
   logic [31:0]               hrdata;
   logic                      hresp;

   scr1_imem_ahb_q #(.REQ_FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_req     (imem_req),
      .imem_req_ack (imem_req_ack),
      .imem_addr    (imem_addr),
      .imem_flush   (imem_flush),
      .imem_rdata   (imem_rdata),
      .imem_resp    (imem_resp),
      .req_cnt      (req_cnt),
      .hprot        (hprot),
      .hburst       (hburst),
      .hsize        (hsize),
      .htrans       (htrans),
      .hmastlock    (hmastlock),
      .haddr        (haddr),
      .hready       (hready),
      .hrdata       (hrdata),
      .hresp        (hresp)
   );

   typedef struct {
      int          cyc;
      logic [1:0]  resp;
      logic [31:0] data;
   } rec_t;

   rec_t got_q[$];
   rec_t exp_q[$];
   int   cyc;
   int   n_checks;
   int   n_errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Response log
   always @(negedge clk) begin
      if (imem_resp != SCR1_MEM_RESP_NOTRDY) begin
         got_q.push_back('{cyc, 2'(imem_resp), imem_rdata});
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic req, input logic [31:0] addr, input logic flush,
                        input logic rdy, input logic err, input logic [31:0] rdata);
      imem_req   = req;
      imem_addr  = addr;
      imem_flush = flush;
      hready     = rdy;
      hresp      = err;
      hrdata     = rdata;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
         tick();
      end
   endtask

   task automatic expect_resp(input int c, input logic [1:0] r, input logic [31:0] d);
      exp_q.push_back('{c, r, d});
   endtask

   task automatic match_resps(input string tag);
      check_eq({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check_eq({tag, "_cycle"}, 32'(got_q[i].cyc), 32'(exp_q[i].cyc));
         check_eq({tag, "_kind"},  32'(got_q[i].resp), 32'(exp_q[i].resp));
         check_eq({tag, "_data"},  got_q[i].data, exp_q[i].data);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
      repeat (3) tick();

      // Reset state and constant attributes
      check_eq("rst_ack",    32'(imem_req_ack), 32'd1);
      check_eq("rst_htrans", 32'(htrans), 32'(SCR1_HTRANS_IDLE));
      check_eq("rst_resp",   32'(imem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
      check_eq("rst_cnt",    32'(req_cnt), 32'd0);
      check_eq("hprot",      32'(hprot), 32'd0);
      check_eq("hburst",     32'(hburst), 32'd0);
      check_eq("hsize",      32'(hsize), 32'd2);
      check_eq("hmastlock",  32'(hmastlock), 32'd0);
      rst_n = 1'b1;
      idle(2);

      // Back-to-back fetches with zero wait states
      for (int i = 0; i < 5; i++) begin
         logic [31:0] a;
         a = 32'h100 + 32'(4 * i);
         drive(i < 4, a, 1'b0, 1'b1, 1'b0, (i > 0) ? (32'hD000_0000 | (a - 32'd4)) : 32'h0);
         if (i > 0) expect_resp(cyc + LAT, OK, 32'hD000_0000 | (a - 32'd4));
         if (i < 4) begin
            check_eq("b2b_htrans", 32'(htrans), 32'(SCR1_HTRANS_NONSEQ));
            check_eq("b2b_haddr",  haddr, a);
            check_eq("b2b_ack",    32'(imem_req_ack), 32'd1);
         end else begin
            check_eq("b2b_idle", 32'(htrans), 32'(SCR1_HTRANS_IDLE));
         end
         tick();
         check_eq("b2b_cnt", 32'(req_cnt), 32'd0);
      end
      idle(2);
      match_resps("b2b");

      // Full back-pressure while the slave stalls
      drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
      check_eq("bp_htrans0", 32'(htrans), 32'(SCR1_HTRANS_NONSEQ));
      check_eq("bp_ack0",    32'(imem_req_ack), 32'd1);
      tick();
      check_eq("bp_cnt0", 32'(req_cnt), 32'd1);
      drive(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0);
      check_eq("bp_haddr1", haddr, 32'h100);
      check_eq("bp_ack1",   32'(imem_req_ack), 32'd1);
      tick();
      for (int i = 0; i < 3; i++) begin
         check_eq("bp_cnt_sat", 32'(req_cnt), 32'd2);
         drive(1'b1, 32'h108, 1'b0, 1'b0, 1'b0, 32'h0);
         check_eq("bp_ack_full", 32'(imem_req_ack), 32'd0);
         check_eq("bp_haddr",    haddr, 32'h100);
         check_eq("bp_htrans",   32'(htrans), 32'(SCR1_HTRANS_NONSEQ));
         tick();
      end
      check_eq("bp_cnt_hold", 32'(req_cnt), 32'd2);
      drive(1'b1, 32'h108, 1'b0, 1'b1, 1'b0, 32'h0);
      check_eq("bp_ack5",   32'(imem_req_ack), 32'd0);
      check_eq("bp_haddr5", haddr, 32'h100);
      tick();
      check_eq("bp_cnt5", 32'(req_cnt), 32'd1);
      drive(1'b1, 32'h108, 1'b0, 1'b1, 1'b0, 32'hD000_0100);
      expect_resp(cyc + LAT, OK, 32'hD000_0100);
      check_eq("bp_ack6",   32'(imem_req_ack), 32'd1);
      check_eq("bp_haddr6", haddr, 32'h104);
      tick();
      check_eq("bp_cnt6", 32'(req_cnt), 32'd1);
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hD000_0104);
      expect_resp(cyc + LAT, OK, 32'hD000_0104);
      check_eq("bp_haddr7", haddr, 32'h108);
      tick();
      check_eq("bp_cnt7", 32'(req_cnt), 32'd0);
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hD000_0108);
      expect_resp(cyc + LAT, OK, 32'hD000_0108);
      check_eq("bp_htrans8", 32'(htrans), 32'(SCR1_HTRANS_IDLE));
      tick();
      idle(2);
      match_resps("bp");

      // Two-cycle AHB error on the first beat with the queue full
      drive(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0);
      check_eq("err_htrans0", 32'(htrans), 32'(SCR1_HTRANS_NONSEQ));
      tick();
      drive(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      drive(1'b1, 32'h108, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      check_eq("err_cnt_full", 32'(req_cnt), 32'd2);
      drive(1'b1, 32'h10C, 1'b0, 1'b0, 1'b1, 32'h0);
      check_eq("err_htrans_w", 32'(htrans), 32'(SCR1_HTRANS_IDLE));
      tick();
      drive(1'b1, 32'h10C, 1'b0, 1'b1, 1'b1, 32'hE000_0100);
      expect_resp(cyc + LAT, ER, 32'hE000_0100);
      check_eq("err_htrans_b", 32'(htrans), 32'(SCR1_HTRANS_IDLE));
      tick();
      check_eq("err_cnt_clr", 32'(req_cnt), 32'd0);
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
      check_eq("err_htrans_n", 32'(htrans), 32'(SCR1_HTRANS_IDLE));
      tick();
      idle(3);
      match_resps("err");

      // Redirect while a data phase is outstanding
      drive(1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 32'h0);
      check_eq("fl_haddr0", haddr, 32'h200);
      tick();
      drive(1'b1, 32'h204, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      check_eq("fl_cnt1", 32'(req_cnt), 32'd1);
      drive(1'b1, 32'h2F0, 1'b1, 1'b0, 1'b0, 32'h0);
      check_eq("fl_ack",    32'(imem_req_ack), 32'd0);
      check_eq("fl_htrans", 32'(htrans), 32'(SCR1_HTRANS_IDLE));
      tick();
      check_eq("fl_cnt_clr", 32'(req_cnt), 32'd0);
      drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0);
      check_eq("fl_ack3", 32'(imem_req_ack), 32'd1);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hD000_0200);
      check_eq("fl_drop_resp", 32'(imem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
      check_eq("fl_htrans4",   32'(htrans), 32'(SCR1_HTRANS_NONSEQ));
      check_eq("fl_haddr4",    haddr, 32'h300);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hD000_0300);
      expect_resp(cyc + LAT, OK, 32'hD000_0300);
      tick();
      idle(2);
      match_resps("fl");

      // Reset during a stalled data phase, then a fresh fetch
      drive(1'b1, 32'h400, 1'b0, 1'b1, 1'b0, 32'h0);
      tick();
      drive(1'b1, 32'h404, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      rst_n = 1'b0;
      #1;
      check_eq("mrst_cnt",    32'(req_cnt), 32'd0);
      check_eq("mrst_htrans", 32'(htrans), 32'(SCR1_HTRANS_IDLE));
      check_eq("mrst_ack",    32'(imem_req_ack), 32'd1);
      check_eq("mrst_resp",   32'(imem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
      tick();
      tick();
      rst_n = 1'b1;
      drive(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 32'h0);
      check_eq("mrst_addr_state", 32'(htrans), 32'(SCR1_HTRANS_NONSEQ));
      check_eq("mrst_haddr0",     haddr, 32'h500);
      tick();
      check_eq("mrst_cnt1", 32'(req_cnt), 32'd1);
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
      check_eq("mrst_haddr1", haddr, 32'h500);
      tick();
      check_eq("mrst_cnt2", 32'(req_cnt), 32'd0);
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hD000_0500);
      expect_resp(cyc + LAT, OK, 32'hD000_0500);
      tick();
      idle(2);
      match_resps("mrst");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
